// File: rtl/vmem_responder_pkg.sv
// Shared definitions for the vector memory responder: data widths and FSM state encodings.
package vmem_responder_pkg;

    localparam int XLEN         = 32;
    localparam int RAM_DATA_WID = 32;

    typedef enum logic [1:0] {
        VMR_IDLE  = 2'd0,
        VMR_LOAD  = 2'd1,
        VMR_STORE = 2'd2,
        VMR_DRAIN = 2'd3
    } vmr_state_e;

endpackage

// File: rtl/vmr_fifo2.sv
// Two-entry synchronous FIFO; entry 0 is always the head.
// A push into a full FIFO without a simultaneous pop is dropped (the owner never does that).
module vmr_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   count_q, count_d;

    // Next-state for storage and occupancy; push+pop keeps the count unchanged.
    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push_i) begin
                    mem0_d  = din_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop_i) begin
                    mem0_d = din_i;
                end else if (push_i) begin
                    mem1_d  = din_i;
                    count_d = 2'd2;
                end else if (pop_i) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop_i) begin
                    mem0_d = mem1_q;
                    if (push_i) begin
                        mem1_d = din_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Storage and occupancy registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem0_q;
    assign count_o = count_q;

endmodule

// File: rtl/vmem_responder.sv
// Strided vector load/store responder in front of a synchronous single-port RAM.
// Handshakes: a transfer happens on a rising edge where both valid and ready are high;
// valid never waits on ready, and a held valid keeps its payload stable until accepted.
// Load data falls through from ram_dout when the FIFO is empty so the first element
// appears in the same cycle the RAM returns it; otherwise it is parked in the FIFO.
module vmem_responder
    import vmem_responder_pkg::*;
#(
    parameter int VLMAX  = 8,
    parameter int RAM_AW = 17
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [XLEN-1:0]              req_addr,
    input  logic [XLEN-1:0]              req_stride,
    input  logic [$clog2(VLMAX+1)-1:0]   req_vl,
    input  logic                         wdata_valid,
    output logic                         wdata_ready,
    input  logic [RAM_DATA_WID-1:0]      wdata,
    output logic                         rdata_valid,
    input  logic                         rdata_ready,
    output logic [RAM_DATA_WID-1:0]      rdata,
    output logic                         rdata_last,
    output logic                         done,
    output logic [RAM_AW-1:0]            ram_addr,
    output logic                         ram_we,
    output logic [RAM_DATA_WID-1:0]      ram_din,
    input  logic [RAM_DATA_WID-1:0]      ram_dout,
    output vmr_state_e                   dbg_state
);

    localparam int VLW = $clog2(VLMAX + 1);
    localparam int EW  = RAM_DATA_WID + 1;   // {last flag, data}

    vmr_state_e      state_q;
    logic [XLEN-1:0] cur_addr_q;
    logic [XLEN-1:0] stride_q;
    logic [VLW-1:0]  remaining_q;
    logic            inflight_q;
    logic            inflight_last_q;

    logic [EW-1:0]   fifo_head;
    logic [1:0]      fifo_count;
    logic            fifo_push;
    logic            fifo_pop;
    logic [EW-1:0]   head_ent;
    logic            head_valid;
    logic            rd_hs;
    logic            wr_hs;
    logic            issue_rd;
    logic            addr_unused;

    // Only the word-address bits reach the RAM; the rest still wrap modulo 2^XLEN.
    assign addr_unused = ^{cur_addr_q[XLEN-1:RAM_AW+2], cur_addr_q[1:0]};

    assign head_valid = (fifo_count != 2'd0) || inflight_q;
    assign head_ent   = (fifo_count != 2'd0) ? fifo_head : {inflight_last_q, ram_dout};
    assign rd_hs      = head_valid && rdata_ready;
    assign wr_hs      = (state_q == VMR_STORE) && wdata_valid;
    // At most two elements outstanding: buffered plus the one in the RAM pipeline.
    assign issue_rd   = (state_q == VMR_LOAD) && (remaining_q != '0) &&
                        ((fifo_count + {1'b0, inflight_q}) < 2'd2);
    assign fifo_push  = inflight_q && !(rd_hs && (fifo_count == 2'd0));
    assign fifo_pop   = rd_hs && (fifo_count != 2'd0);

    vmr_fifo2 #(.W(EW)) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({inflight_last_q, ram_dout}),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Request sequencing: capture, walk addresses, track the in-flight read, finish.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= VMR_IDLE;
            cur_addr_q      <= '0;
            stride_q        <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue_rd;
            inflight_last_q <= issue_rd && (remaining_q == VLW'(1));
            case (state_q)
                VMR_IDLE: begin
                    if (req_valid) begin
                        cur_addr_q  <= req_addr;
                        stride_q    <= req_stride;
                        remaining_q <= req_vl;
                        if (req_vl == '0) begin
                            state_q <= VMR_DRAIN;
                        end else if (req_we) begin
                            state_q <= VMR_STORE;
                        end else begin
                            state_q <= VMR_LOAD;
                        end
                    end
                end
                VMR_LOAD: begin
                    if (issue_rd) begin
                        cur_addr_q  <= cur_addr_q + stride_q;
                        remaining_q <= remaining_q - VLW'(1);
                    end
                    if (rd_hs && head_ent[EW-1]) begin
                        state_q <= VMR_DRAIN;
                    end
                end
                VMR_STORE: begin
                    if (wr_hs) begin
                        cur_addr_q  <= cur_addr_q + stride_q;
                        remaining_q <= remaining_q - VLW'(1);
                        if (remaining_q == VLW'(1)) begin
                            state_q <= VMR_DRAIN;
                        end
                    end
                end
                default: begin
                    state_q <= VMR_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = rst_in && (state_q == VMR_IDLE);
    assign wdata_ready = (state_q == VMR_STORE);
    assign rdata_valid = head_valid;
    assign rdata       = head_valid ? head_ent[RAM_DATA_WID-1:0] : '0;
    assign rdata_last  = head_valid && head_ent[EW-1];
    assign done        = (state_q == VMR_DRAIN);
    assign ram_addr    = cur_addr_q[RAM_AW+1:2];
    assign ram_we      = wr_hs;
    assign ram_din     = wr_hs ? wdata : '0;
    assign dbg_state   = state_q;

endmodule

// File: doc/vmem_responder.md
# vmem_responder

Memory-side responder for the VPU's vector load/store traffic. It accepts one strided vector request at a time (base, stride, element count), walks the synchronous single-port RAM one element per cycle, streams load data back under backpressure, and accepts store data element by element. It sits between `vpu` and `ram` in `riscv_top`. It replaces direct VPU address driving with a request/response handshake.

## Interface
- `VLMAX`, 8: maximum elements per request; `req_vl` width is `$clog2(VLMAX+1)`.
- `RAM_AW`, 17: RAM word-address width.
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  `XLEN`  byte base address.
- `req_stride`  in  `XLEN`  byte stride, two's complement.
- `req_vl`  in  clog2(VLMAX+1)  element count, 0..VLMAX.
- `wdata_valid`  in  1  store element present.
- `wdata_ready`  out  1  store element accepted this cycle.
- `wdata`  in  `RAM_DATA_WID`  store element.
- `rdata_valid`  out  1  load element present.
- `rdata_ready`  in  1  consumer takes the element.
- `rdata`  out  `RAM_DATA_WID`  load element.
- `rdata_last`  out  1  the current `rdata` is the final element.
- `done`  out  1  one-cycle pulse when the request completes.
- `ram_addr`  out  `RAM_AW`  RAM word address.
- `ram_we`  out  1  RAM write enable.
- `ram_din`  out  `RAM_DATA_WID`  RAM write data.
- `ram_dout`  in  `RAM_DATA_WID`  RAM read data, valid 1 cycle after the address.

## Operation
- **States.** `IDLE`, `LOAD`, `STORE`, `DRAIN`.
- **IDLE.**
  - `req_ready`=1.
  - On `req_valid`, latch addr, stride, vl and we; set `remaining`=vl.
  - vl=0: go to `DRAIN` with no RAM access and no `rdata`.
  - Otherwise go to `LOAD` or `STORE` according to `req_we`.
- **Addressing.**
  - `ram_addr` = `cur_addr[RAM_AW+1:2]`; address bits [1:0] are ignored.
  - `cur_addr` += `stride` modulo 2^XLEN after each issued element. Wrap-around is silent.
- **LOAD.**
  - Issue a read when `fifo_count + inflight < 2`. `inflight` is a 1-bit flag for a read issued the previous cycle.
  - Returned `ram_dout` is pushed into a 2-entry FIFO.
  - `rdata`/`rdata_valid` are driven from the FIFO head.
  - `rdata_last` = head is the final element.
  - Leave `LOAD` once every element has been issued and the final element's handshake completes; go to `DRAIN`.
- **STORE.**
  - `wdata_ready`=1 in every `STORE` cycle.
  - On `wdata_valid`: `ram_we`=1, `ram_din`=`wdata`, `ram_addr` = current element, then advance.
  - After the last write, go to `DRAIN`.
- **DRAIN.** Pulse `done` for one cycle and return to `IDLE`. `req_ready` is 0 during `DRAIN`.
- **Outside the active states.** `wdata_ready`=0 outside `STORE`. `ram_we`=0 outside `STORE` handshakes.
- **Reset**, asynchronous, including mid-request:
  - State→`IDLE`; FIFO, `inflight`, `remaining` and `cur_addr` cleared.
  - All outputs 0, except `req_ready`, which is 1 after deassertion.
  - A partially completed store is not rolled back.

## Timing
- Request accepted at edge T. The first RAM read or write is issued in cycle T+1.
- Load latency: first `rdata_valid` in cycle T+2 (read in T+1, FIFO push at edge T+2).
- Load throughput: with `rdata_ready` held at 1, one element per cycle. For vl=n the last handshake is in cycle T+n+1 and `done` is in T+n+2.
- `rdata_ready`=0: `rdata` and `rdata_last` hold stable. At most 2 elements are buffered, and reads stall until there is room. No element is lost or duplicated.
- Store: one element per cycle when `wdata_valid` is held. `done` is in the cycle after the last write.
- Simultaneous FIFO push and pop leaves the count unchanged.
- `req_valid` outside `IDLE` is ignored; the requester holds it.
- vl=0: `done` in T+1, `req_ready` again in T+2.

## Structure
- **Shared macros file (existing):** `XLEN` and `RAM_DATA_WID`. Add state encodings `VMR_IDLE`, `VMR_LOAD`, `VMR_STORE` and `VMR_DRAIN`.
- **Sub-module:** `vmr_fifo2`, a 2-entry synchronous FIFO with count, push, pop and head outputs. It is reused for load return data.
- **Top-level wiring:** `riscv_top` instantiates `vmem_responder` between `vpu` and `ram` port a/b.

## Test plan
- **Unit-stride load.** RAM words 0x10–0x13 = A0,A1,A2,A3; load addr=0x40, stride=4, vl=4, `rdata_ready`=1 → `rdata` A0..A3 in cycles T+2..T+5, `rdata_last` only on A3, `done` at T+6.
- **Strided store with gaps.** Store addr=0x100, stride=-8, vl=3, `wdata` 11,22,33, with `wdata_valid` low for 2 cycles mid-burst → words 0x40=11, 0x3E=22, 0x3C=33; no other writes.
- **Load backpressure.** vl=8, `rdata_ready` toggled 1,0,0,1 repeating → all 8 elements delivered in order exactly once; `ram_addr` never runs more than 2 elements ahead of the consumer.
- **vl=0.** Either direction → `done` at T+1; `ram_we`=0 and `rdata_valid`=0 throughout.
- **Address wrap.** addr=0xFFFF_FFFC, stride=4, vl=2 → reads word `RAM_AW` all-ones, then word 0.
- **Reset mid-load.** `rst_in` low during element 3 of a vl=8 load → all outputs 0 immediately; after release `req_ready`=1 and a new vl=1 load returns correct data.
